// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues sequential imem reads, buffers tagged words in a skid FIFO for decode
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW+1:0] occupancy;
    logic          pop;
    logic          push;
    logic          issue;

    assign inst_valid = ~reset & (count != '0);
    assign pop        = inst_valid & inst_ready;
    assign push       = inflight & ~redirect_valid;
    // slots committed after this cycle: buffered words plus the one still in flight, minus the one leaving
    assign occupancy  = {1'b0, count} + (AW+2)'(inflight) - (AW+2)'(pop);
    assign issue      = ~reset & ~redirect_valid & (occupancy < (AW+2)'(DEPTH));
    assign imem_req   = issue;
    assign imem_addr  = reset ? RESET_PC : fetch_pc;
    assign inst_out   = inst_valid ? fifo_inst[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr] : '0;

    // PC advance, in-flight flag and FIFO pointers; redirect flushes everything buffered
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (issue) fetch_pc <= fetch_pc + 32'd4;
            inflight <= issue;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // storage and the in-flight PC tag are qualified by count/inflight, so they need no reset
    always_ff @(posedge clk) begin
        if (issue) inflight_pc <= fetch_pc;
        if (push) begin
            fifo_pc[wr_ptr]   <= inflight_pc;
            fifo_inst[wr_ptr] <= imem_rdata;
        end
    end

    // the issue throttle must keep a returning word from landing on a full FIFO
    always_ff @(posedge clk) begin
        if (!reset) assert (!(push && !pop && count == (AW+1)'(DEPTH)));
    end
endmodule
